// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit for the RV32M operation set.
//   Multiply: shift-add on operand magnitudes, one multiplier bit per cycle,
//             32 iterations, sign applied to the 64-bit product at the end.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle,
//             32 iterations; quotient truncates toward zero, remainder takes
//             the sign of the dividend.
//   Divide-by-zero and signed overflow bypass the iterations and go straight
//   to DONE with the architecturally defined result.
// States: IDLE (StIdle), MUL (StMul), DIV (StDiv), DONE (StDone).
//
// Ports
//   clk_i    in   1   clock, rising edge
//   rst_ni   in   1   asynchronous active-low reset
//   valid_i  in   1   request valid
//   ready_o  out  1   unit can accept a request (IDLE only)
//   A_i      in  32   multiplicand / dividend
//   B_i      in  32   multiplier / divisor
//   op_i     in   3   0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   flush_i  in   1   abort any in-flight operation
//   C_o      out 32   result, holds last value while valid_o is 0
//   valid_o  out  1   C_o valid
//   ready_i  in   1   consumer accepts result
// -----------------------------------------------------------------------------
module muldiv_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   input  logic [2:0]  op_i,
   input  logic        flush_i,
   output logic [31:0] C_o,
   output logic        valid_o,
   input  logic        ready_i
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

   state_t      r_state;
   logic        r_ready;
   logic        r_valid;
   logic [31:0] r_c;
   logic [4:0]  r_cnt;
   logic [2:0]  r_op;
   // r_hi: product high half (MUL) or partial remainder (DIV)
   // r_lo: multiplier shifting out / product low half shifting in (MUL),
   //       dividend shifting out / quotient shifting in (DIV)
   // r_mcand: multiplicand magnitude (MUL) or divisor magnitude (DIV)
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_mcand;
   logic        r_neg;     // negate product / quotient
   logic        r_neg_a;   // negate remainder (dividend was negative)

   // Request decode
   logic        w_a_sgn;
   logic        w_b_sgn;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_div_zero;
   logic        w_ovf;
   logic [31:0] w_special;

   // Datapath
   logic [32:0] w_mul_sum;
   logic [63:0] w_prod;
   logic [63:0] w_prod_fix;
   logic [31:0] w_mul_res;
   logic [32:0] w_shift;
   logic        w_qbit;
   logic [31:0] w_sub;
   logic [31:0] w_rem_next;
   logic [31:0] w_quo_next;
   logic [31:0] w_div_res;

   always_comb begin
      // Divide ops: DIV/REM (op[0]=0) signed. Multiply ops: A signed unless
      // MULHU, B signed only for MUL/MULH.
      w_a_sgn    = op_i[2] ? ~op_i[0] : (op_i != 3'd3);
      w_b_sgn    = op_i[2] ? ~op_i[0] : ~op_i[1];
      w_a_neg    = w_a_sgn & A_i[31];
      w_b_neg    = w_b_sgn & B_i[31];
      w_a_mag    = w_a_neg ? (32'd0 - A_i) : A_i;
      w_b_mag    = w_b_neg ? (32'd0 - B_i) : B_i;
      w_div_zero = (B_i == 32'd0);
      w_ovf      = ~op_i[0] && (A_i == 32'h8000_0000) && (B_i == 32'hFFFF_FFFF);
      // op[1] selects remainder
      if (w_div_zero) begin
         w_special = op_i[1] ? A_i : 32'hFFFF_FFFF;
      end else begin
         w_special = op_i[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   always_comb begin
      // Shift-add step: add multiplicand when the current multiplier bit is
      // set, then shift the {carry, hi, lo} pair right by one.
      w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 33'd0);
      w_prod     = {w_mul_sum, r_lo[31:1]};
      w_prod_fix = r_neg ? (64'd0 - w_prod) : w_prod;
      w_mul_res  = (r_op == 3'd0) ? w_prod_fix[31:0] : w_prod_fix[63:32];

      // Restoring step: the partial remainder is always below the divisor, so
      // a successful subtraction always fits back into 32 bits.
      w_shift    = {r_hi, r_lo[31]};
      w_qbit     = (w_shift >= {1'b0, r_mcand});
      w_sub      = w_shift[31:0] - r_mcand;
      w_rem_next = w_qbit ? w_sub : w_shift[31:0];
      w_quo_next = {r_lo[30:0], w_qbit};
      if (r_op[1]) begin
         w_div_res = r_neg_a ? (32'd0 - w_rem_next) : w_rem_next;
      end else begin
         w_div_res = r_neg ? (32'd0 - w_quo_next) : w_quo_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_c     <= 32'd0;
         r_cnt   <= 5'd0;
         r_op    <= 3'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_mcand <= 32'd0;
         r_neg   <= 1'b0;
         r_neg_a <= 1'b0;
      end else if (flush_i) begin
         // Flush beats both acceptance and result handshake; C_o keeps its
         // last presented value.
         r_state <= StIdle;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_cnt   <= 5'd0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (valid_i) begin
                  r_op    <= op_i;
                  r_cnt   <= 5'd0;
                  r_ready <= 1'b0;
                  if (op_i[2] && (w_div_zero || w_ovf)) begin
                     r_state <= StDone;
                     r_valid <= 1'b1;
                     r_c     <= w_special;
                  end else begin
                     r_state <= op_i[2] ? StDiv : StMul;
                     r_hi    <= 32'd0;
                     r_lo    <= op_i[2] ? w_a_mag : w_b_mag;
                     r_mcand <= op_i[2] ? w_b_mag : w_a_mag;
                     r_neg   <= w_a_neg ^ w_b_neg;
                     r_neg_a <= w_a_neg;
                  end
               end
            end
            StMul: begin
               r_hi  <= w_mul_sum[32:1];
               r_lo  <= {w_mul_sum[0], r_lo[31:1]};
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state <= StDone;
                  r_valid <= 1'b1;
                  r_c     <= w_mul_res;
                  r_cnt   <= 5'd0;
               end
            end
            StDiv: begin
               r_hi  <= w_rem_next;
               r_lo  <= w_quo_next;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state <= StDone;
                  r_valid <= 1'b1;
                  r_c     <= w_div_res;
                  r_cnt   <= 5'd0;
               end
            end
            StDone: begin
               if (ready_i) begin
                  r_state <= StIdle;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign C_o     = r_c;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk_i;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] A_i;
   logic [31:0] B_i;
   logic [2:0]  op_i;
   logic        flush_i;
   logic [31:0] C_o;
   logic        valid_o;
   logic        ready_i;

   int checks;
   int errors;

   muldiv_unit dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .A_i     (A_i),
      .B_i     (B_i),
      .op_i    (op_i),
      .flush_i (flush_i),
      .C_o     (C_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Issue one request and wait for valid_o. lat is the cycle index of the
   // first valid_o relative to the acceptance cycle (1 = the cycle right after
   // the acceptance edge). 999 means valid_o never arrived.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      valid_i = 1'b1;
      op_i    = op;
      A_i     = a;
      B_i     = b;
      @(posedge clk_i);
      #1;
      // Scramble inputs: only the acceptance-edge values may matter
      valid_i = 1'b0;
      A_i     = 32'hDEAD_BEEF;
      B_i     = 32'h1234_5678;
      op_i    = ~op;
      lat     = 1;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      if (!valid_o) lat = 999;
      res = C_o;
   endtask

   task automatic consume();
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      A_i     = '0;
      B_i     = '0;
      op_i    = '0;
      #12;
      checks++;
      if (ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", ready_o);
      end
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
      end
      checks++;
      if (C_o !== 32'd0) begin
         errors++; $display("FAIL reset_c: got %h want 00000000", C_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_mul();
      logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1};
      logic [31:0] as  [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] bs  [6] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd5, 32'hFFFF_FFFF};
      logic [31:0] exp [6] = '{32'h0000_002A, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFF1, 32'h0000_0000};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], res, lat);
         checks++;
         if (res !== exp[i]) begin
            errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]);
         end
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat);
         end
         consume();
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops [7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5};
      logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd7, 32'd7, 32'h8000_0000};
      logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd7, 32'd7,
                               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] exp [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFD, 32'd1, 32'd0};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         do_op(ops[i], as[i], bs[i], res, lat);
         checks++;
         if (res !== exp[i]) begin
            errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]);
         end
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat);
         end
         consume();
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops [6] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd6, 3'd4};
      logic [31:0] as  [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'd0, 32'h8000_0000};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], res, lat);
         checks++;
         if (res !== exp[i]) begin
            errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, exp[i]);
         end
         checks++;
         if (lat != 1) begin
            errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat);
         end
         consume();
      end
   endtask

   task automatic test_hold();
      logic [31:0] res;
      int          lat;
      do_op(3'd0, 32'd7, 32'd6, res, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         checks++;
         if (valid_o !== 1'b1 || C_o !== 32'h0000_002A) begin
            errors++;
            $display("FAIL hold[%0d]: got valid=%b c=%h want valid=1 c=0000002a", i, valid_o, C_o);
         end
      end
      consume();
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int          lat;
      do_op(3'd5, 32'd100, 32'd7, res, lat);
      consume();
      // Re-issue immediately in the first IDLE cycle
      do_op(3'd7, 32'd100, 32'd7, res, lat);
      checks++;
      if (res !== 32'd2 || lat != 33) begin
         errors++; $display("FAIL back_to_back: got %h lat %0d want 00000002 lat 33", res, lat);
      end
      consume();
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      int          seen;
      valid_i = 1'b1;
      op_i    = 3'd5;
      A_i     = 32'd100;
      B_i     = 32'd7;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (9) begin
         @(posedge clk_i);
         #1;
      end
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_div: got valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL flush_stale: got %0d valid cycles want 0", seen);
      end
      do_op(3'd0, 32'd3, 32'd5, res, lat);
      checks++;
      if (res !== 32'd15 || lat != 33) begin
         errors++; $display("FAIL flush_then_mul: got %h lat %0d want 0000000f lat 33", res, lat);
      end
      consume();

      // Flush together with an otherwise valid acceptance: request dropped
      valid_i = 1'b1;
      flush_i = 1'b1;
      op_i    = 3'd0;
      A_i     = 32'd2;
      B_i     = 32'd2;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid_o || !ready_o) seen++;
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL flush_vs_accept: got %0d busy/valid cycles want 0", seen);
      end

      // Flush together with the result handshake
      do_op(3'd4, 32'd9, 32'd0, res, lat);
      ready_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      flush_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || C_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL flush_vs_handshake: got valid=%b ready=%b c=%h want 0 1 ffffffff",
                  valid_o, ready_o, C_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat;
      int          seen;
      valid_i = 1'b1;
      op_i    = 3'd0;
      A_i     = 32'd7;
      B_i     = 32'd6;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (19) begin
         @(posedge clk_i);
         #1;
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || C_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got ready=%b valid=%b c=%h want 1 0 00000000",
                  ready_o, valid_o, C_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL reset_stale: got %0d valid cycles want 0", seen);
      end
      do_op(3'd0, 32'd7, 32'd6, res, lat);
      checks++;
      if (res !== 32'h0000_002A || lat != 33) begin
         errors++; $display("FAIL reset_then_mul: got %h lat %0d want 0000002a lat 33", res, lat);
      end
      consume();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_hold();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; operand and result width fixed at 32 bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_ni.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  unit can accept a request.
REQ-007 A_i  input  32  operand A: multiplicand or dividend.
REQ-008 B_i  input  32  operand B: multiplier or divisor.
REQ-009 op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 flush_i  input  1  abort any in-flight operation.
REQ-011 C_o  output  32  result.
REQ-012 valid_o  output  1  C_o valid.
REQ-013 ready_i  input  1  consumer accepts result.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, DONE.
REQ-015 Acceptance SHALL occur on a rising edge with valid_i=1, ready_o=1, flush_i=0; A_i, B_i and op_i are captured at that edge.
REQ-016 ready_o SHALL be 1 only in IDLE; inputs outside acceptance are ignored.
REQ-017 On acceptance, IDLE SHALL go to MUL for op 0-3 and to DIV for op 4-7.
REQ-018 MUL SHALL run 32 iterations, shift-add, one bit per cycle, on operand magnitudes per signedness, producing a 64-bit product.
REQ-019 Signedness: MUL/MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned x unsigned.
REQ-020 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32], sign-corrected.
REQ-021 DIV SHALL run 32 iterations of restoring division on magnitudes, one quotient bit per cycle.
REQ-022 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-023 Normal latency: valid_o SHALL first be 1 exactly 33 cycles after the acceptance edge (acceptance in cycle N gives valid_o in cycle N+33).
REQ-024 Divide by zero SHALL skip DIV and go IDLE to DONE, with valid_o in cycle N+1.
REQ-025 Divide-by-zero results: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
REQ-026 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL also go IDLE to DONE in one cycle.
REQ-027 Signed-overflow results: DIV gives 0x80000000; REM gives 0.
REQ-028 After the last iteration, MUL or DIV SHALL go to DONE.
REQ-029 In DONE, valid_o=1 and C_o SHALL stay stable until an edge with ready_i=1.
REQ-030 On an edge in DONE with ready_i=1, the unit SHALL return to IDLE, with ready_o=1 and valid_o=0 in the next cycle; no same-cycle re-accept.
REQ-031 flush_i=1 at an edge SHALL force IDLE from any state, with valid_o=0 next cycle; the aborted result is never presented.
REQ-032 flush_i SHALL win over a simultaneous acceptance (request dropped) and over a simultaneous result handshake.
REQ-033 C_o SHALL hold its last value when valid_o=0 and SHALL be 0 after reset.

Reset
REQ-034 rst_ni=0 SHALL immediately, without a clock, force state IDLE, ready_o=1, valid_o=0, C_o=0, iteration counter 0.
REQ-035 Reset mid-operation SHALL discard the operation; the first accept after deassertion behaves as from a clean start.

Verification
REQ-036 MUL A=7, B=6, accepted in cycle N: C_o=0x0000002A, valid_o=1 first in cycle N+33.
REQ-037 MULH A=B=0x80000000: C_o=0x40000000.
REQ-038 MULHU A=B=0xFFFFFFFF: C_o=0xFFFFFFFE.
REQ-039 DIV A=0xFFFFFFF9 (-7), B=2: C_o=0xFFFFFFFD.
REQ-040 REM with the same operands as REQ-039: C_o=0xFFFFFFFF.
REQ-041 DIVU A=7, B=0: C_o=0xFFFFFFFF with valid_o in cycle N+1.
REQ-042 REM A=0x80000000, B=0xFFFFFFFF: C_o=0 with valid_o in cycle N+1.
REQ-043 Hold ready_i=0 for 5 cycles after valid_o: C_o and valid_o stay stable; raising ready_i gives valid_o=0 and ready_o=1 next cycle.
REQ-044 flush_i at cycle N+10 of a DIV: valid_o stays 0, ready_o=1 in N+11; a new MUL 3x5 then returns 15.
REQ-045 rst_ni pulsed low at cycle N+20 of a MUL: outputs reset immediately; no stale valid_o after deassertion.
